// File: rtl/bitwise_sweep_checker_if.sv
// Operand/result link between the sweep checker and the bitwise operator block.
// The checker (master) drives the 4-bit operand and samples the 18 result flags;
// the operator block (slave) consumes the operand and returns the flags.
interface bitwise_sweep_checker_if;
  logic [3:0]  stim;
  logic [17:0] res;

  modport master (output stim, input res);
  modport slave  (input stim, output res);
endinterface

// File: rtl/bitwise_sweep_checker.sv
// Sweep checker for the combinational bitwise/logical-operator block.
// Drives all 16 operand values in order, waits SETTLE cycles for each, then
// compares the 18 result flags against a built-in golden model. Reports a
// saturating mismatch count plus the operand and difference mask of the first
// failing vector.
module bitwise_sweep_checker #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  bitwise_sweep_checker_if.master chk,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_cnt,
  output logic [3:0]              first_err_vec,
  output logic [17:0]             first_err_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Settle counter reload: DRIVE lasts SETTLE cycles, counting SETTLE-1 down to 0.
  localparam logic [3:0]       SETTLE_RLD = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  // Expected flags of the operator block for operand v.
  function automatic logic [17:0] exp_flags(input logic [3:0] v);
    logic        a;
    logic        b;
    logic        lo;
    logic        hi;
    logic [17:0] e;
    a     = v[0];
    b     = v[1];
    lo    = |v[1:0];
    hi    = |v[3:2];
    e[0]  = a & b;
    e[1]  = a | b;
    e[2]  = ~(a & b);
    e[3]  = ~(a | b);
    e[4]  = a ^ b;
    e[5]  = ~(a ^ b);
    e[6]  = ~(a ^ b);
    e[7]  = ~a;
    e[8]  = a;
    e[9]  = a;
    e[10] = a;
    e[11] = ~a;
    e[12] = ~a;
    e[13] = a;
    e[14] = ~a;
    e[15] = ~a;
    e[16] = lo & hi;
    e[17] = lo | hi;
    return e;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        stim_q, stim_d;
  logic [3:0]        settle_q, settle_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [3:0]        first_err_vec_q, first_err_vec_d;
  logic [17:0]       first_err_mask_q, first_err_mask_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [17:0]       diff;

  // Next-state logic: sweep sequencing, result comparison and error capture.
  always_comb begin
    state_d          = state_q;
    stim_d           = stim_q;
    settle_d         = settle_q;
    err_cnt_d        = err_cnt_q;
    first_err_vec_d  = first_err_vec_q;
    first_err_mask_d = first_err_mask_q;
    diff             = chk.res ^ exp_flags(stim_q);

    case (state_q)
      IDLE, DONE: begin
        // A new sweep wipes all results of the previous one.
        if (start) begin
          state_d          = DRIVE;
          stim_d           = 4'd0;
          settle_d         = SETTLE_RLD;
          err_cnt_d        = '0;
          first_err_vec_d  = 4'd0;
          first_err_mask_d = 18'd0;
        end
      end
      DRIVE: begin
        if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        if (|diff) begin
          err_cnt_d = sat_inc(err_cnt_q);
          // Only the very first failing vector is captured.
          if (err_cnt_q == '0) begin
            first_err_vec_d  = stim_q;
            first_err_mask_d = diff;
          end
        end
        if (stim_q == 4'hF) begin
          state_d = DONE;
        end else begin
          stim_d   = stim_q + 4'd1;
          settle_d = SETTLE_RLD;
          state_d  = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered so done and pass rise on the same edge.
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_cnt_d == '0);
  end

  // State register; reset aborts any sweep and discards partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      stim_q           <= 4'd0;
      settle_q         <= 4'd0;
      err_cnt_q        <= '0;
      first_err_vec_q  <= 4'd0;
      first_err_mask_q <= 18'd0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      stim_q           <= stim_d;
      settle_q         <= settle_d;
      err_cnt_q        <= err_cnt_d;
      first_err_vec_q  <= first_err_vec_d;
      first_err_mask_q <= first_err_mask_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
    end
  end

  assign chk.stim       = stim_q;
  assign busy           = (state_q == DRIVE) || (state_q == CHECK);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_vec  = first_err_vec_q;
  assign first_err_mask = first_err_mask_q;

endmodule

// File: tb/tb_bitwise_sweep_checker.sv
// Bench for bitwise_sweep_checker: two instances (SETTLE=1/ERR_W=5 with a
// combinational block model, SETTLE=3/ERR_W=3 with a 2-cycle-delayed model),
// per-vector fault tables, a scoreboard of expected sweep results and a single
// negedge monitor that does all comparisons.
module tb_bitwise_sweep_checker;

  typedef struct {
    int cnt;
    int vec;
    int mask;
    bit pass;
    int cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [4:0]  err_a;
  logic [2:0]  err_b;
  logic [3:0]  fv_a, fv_b;
  logic [17:0] fm_a, fm_b;

  bit [17:0] fault_a [16];
  bit [17:0] fault_b [16];
  logic [3:0] b_d1, b_d2;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_errors = 0;
  bit end_req  = 1'b0;

  bitwise_sweep_checker_if ifa ();
  bitwise_sweep_checker_if ifb ();

  always #5 clk = ~clk;

  bitwise_sweep_checker #(.SETTLE(1), .ERR_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .chk(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_vec(fv_a), .first_err_mask(fm_a)
  );

  bitwise_sweep_checker #(.SETTLE(3), .ERR_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .chk(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_vec(fv_b), .first_err_mask(fm_b)
  );

  // Reference operator block, written from the flag definitions with integer arithmetic.
  function automatic bit [17:0] tb_golden(input logic [3:0] v);
    int a, b, ones;
    bit lo, hi;
    bit [17:0] r;
    a    = int'(v) % 2;
    b    = (int'(v) / 2) % 2;
    ones = a + b;
    lo   = (int'(v) % 4) != 0;
    hi   = (int'(v) / 4) != 0;
    r    = '0;
    r[0] = (ones == 2);
    r[1] = (ones >= 1);
    r[2] = (ones != 2);
    r[3] = (ones == 0);
    r[4] = (ones == 1);
    r[5] = (ones != 1);
    r[6] = (ones != 1);
    r[7] = (a == 0);
    foreach (r[k]) begin
      if (k == 8 || k == 9 || k == 10 || k == 13) r[k] = (a == 1);
      if (k == 11 || k == 12 || k == 14 || k == 15) r[k] = (a == 0);
    end
    r[16] = lo && hi;
    r[17] = lo || hi;
    return r;
  endfunction

  // Block models: response = golden flags corrupted by the per-operand fault table.
  assign ifa.res = tb_golden(ifa.stim) ^ fault_a[ifa.stim];

  always @(posedge clk) begin
    b_d1 <= ifb.stim;
    b_d2 <= b_d1;
  end
  assign ifb.res = tb_golden(b_d2) ^ fault_b[b_d2];

  // Whole-sweep outcome predicted from the list of responses the block gives.
  function automatic exp_t predict(input bit [17:0] flt [16], input int errw, input int settle);
    exp_t e;
    bit found;
    bit [17:0] want, seen;
    int sat;
    sat   = (1 << errw) - 1;
    found = 1'b0;
    e.cnt = 0;
    e.vec = 0;
    e.mask = 0;
    for (int v = 0; v < 16; v++) begin
      want = tb_golden(4'(v));
      seen = want ^ flt[v];
      if (seen != want) begin
        if (!found) begin
          found  = 1'b1;
          e.vec  = v;
          e.mask = int'(seen ^ want);
        end
        e.cnt = (e.cnt < sat) ? e.cnt + 1 : sat;
      end
    end
    e.pass   = !found;
    e.cycles = 16 * (settle + 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor bookkeeping, touched only by the monitor process.
  int   busy_cnt [2];
  bit   busy_prev [2];
  bit   done_prev [2];
  int   stim_prev [2];
  bit   rst_prev = 1'b0;

  task automatic check_reset(input string tag, input logic [31:0] stm, input logic bsy,
                             input logic dn, input logic ps, input logic [31:0] err,
                             input logic [31:0] vec, input logic [31:0] mask);
    check({tag, " reset stim"}, stm, 0);
    check({tag, " reset busy"}, 32'(bsy), 0);
    check({tag, " reset done"}, 32'(dn), 0);
    check({tag, " reset pass"}, 32'(ps), 0);
    check({tag, " reset err_cnt"}, err, 0);
    check({tag, " reset first_err_vec"}, vec, 0);
    check({tag, " reset first_err_mask"}, mask, 0);
  endtask

  task automatic mon(input int i, input string tag, input logic bsy, input logic dn,
                     input logic ps, input logic [31:0] err, input logic [31:0] vec,
                     input logic [31:0] mask, input logic [31:0] stm);
    exp_t e;
    if (bsy) begin
      if (busy_prev[i] && int'(stm) != stim_prev[i])
        check({tag, " stim step"}, stm, 32'((stim_prev[i] + 1) % 16));
      busy_cnt[i] = busy_prev[i] ? busy_cnt[i] + 1 : 1;
    end
    if (dn && !done_prev[i]) begin
      if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s done: got done=1, expected no sweep pending", tag);
      end else begin
        e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
        check({tag, " err_cnt"}, err, 32'(e.cnt));
        check({tag, " first_err_vec"}, vec, 32'(e.vec));
        check({tag, " first_err_mask"}, mask, 32'(e.mask));
        check({tag, " pass"}, 32'(ps), 32'(e.pass));
        check({tag, " busy cycles"}, 32'(busy_cnt[i]), 32'(e.cycles));
        check({tag, " final stim"}, stm, 32'hF);
        check({tag, " busy at done"}, 32'(bsy), 0);
      end
    end
    busy_prev[i] = bsy;
    done_prev[i] = dn;
    stim_prev[i] = int'(stm);
  endtask

  // Monitor: every comparison happens here, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check_reset("A", 32'(ifa.stim), busy_a, done_a, pass_a, 32'(err_a), 32'(fv_a), 32'(fm_a));
        check_reset("B", 32'(ifb.stim), busy_b, done_b, pass_b, 32'(err_b), 32'(fv_b), 32'(fm_b));
      end
      if (rst || rst_prev) begin
        for (int i = 0; i < 2; i++) begin
          busy_cnt[i]  = 0;
          busy_prev[i] = 1'b0;
          done_prev[i] = 1'b0;
          stim_prev[i] = 0;
        end
      end else begin
        mon(0, "A", busy_a, done_a, pass_a, 32'(err_a), 32'(fv_a), 32'(fm_a), 32'(ifa.stim));
        mon(1, "B", busy_b, done_b, pass_b, 32'(err_b), 32'(fv_b), 32'(fm_b), 32'(ifb.stim));
      end
      rst_prev = rst;
      if (end_req) begin
        check("A scoreboard drained", 32'(q_a.size()), 0);
        check("B scoreboard drained", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i);
    int k;
    for (k = 0; k < 300; k++) begin
      if ((i == 0 && done_a) || (i == 1 && done_b)) break;
      tick();
    end
    if (k == 300) begin
      $display("FAIL sweep %0d timeout: done not seen after 300 cycles", i);
      $fatal(1, "timeout");
    end
    tick();
  endtask

  task automatic run_a(input int hold);
    q_a.push_back(predict(fault_a, 5, 1));
    start_a = 1'b1;
    tick();
    repeat (hold) tick();
    start_a = 1'b0;
    wait_done(0);
  endtask

  task automatic run_b();
    q_b.push_back(predict(fault_b, 3, 3));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1);
  endtask

  task automatic set_fault_a(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        0: fault_a[v] = '0;
        1: fault_a[v] = tb_golden(4'(v)) & 18'h10000;
        default: fault_a[v] = ($urandom_range(3) == 0) ? 18'($urandom) : 18'd0;
      endcase
    end
  endtask

  task automatic set_fault_b(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        0: fault_b[v] = '0;
        1: fault_b[v] = 18'h3FFFF;
        default: fault_b[v] = ($urandom_range(2) == 0) ? 18'($urandom) : 18'd0;
      endcase
    end
  endtask

  // Stimulus sequence.
  initial begin
    int k;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    set_fault_a(0);
    set_fault_b(0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Ideal block, then bit16 stuck low, then random fault patterns.
    run_a(0);
    set_fault_a(1);
    run_a(0);
    for (int r = 0; r < 3; r++) begin
      set_fault_a(2);
      run_a(0);
    end

    // start held through most of the sweep must not disturb it.
    set_fault_a(0);
    run_a(20);

    // Abort mid-sweep with reset, then restart from IDLE.
    set_fault_a(1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (k = 0; k < 100 && ifa.stim != 4'd7; k++) tick();
    if (ifa.stim != 4'd7) begin
      $display("FAIL abort setup: stim 7 never reached, got 0x%0h", ifa.stim);
      $fatal(1, "abort setup");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_a(0);

    // Slow instance: delayed block, saturating counter, random faults.
    set_fault_b(0);
    run_b();
    set_fault_b(1);
    run_b();
    for (int r = 0; r < 2; r++) begin
      set_fault_b(2);
      run_b();
    end

    end_req = 1'b1;
  end

endmodule
